// File: rtl/excp_ctrl.sv
// excp_ctrl: exception/interrupt sequencer between the MEM stage and CP0.
// Picks one event per cycle (interrupt > syscall > eret), drives the CP0
// event code and EPC-capture PC, flushes the pipe with a redirect target,
// then stalls fetch for HOLD_CYCLES while the pipeline drains.
module excp_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
    parameter int unsigned HOLD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_syscall,
    input  logic        mem_eret,
    input  logic        mem_cp0we,
    input  logic [4:0]  mem_cp0addr,
    input  logic [31:0] mem_cp0wdata,
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic [31:0] epc,
    input  logic        intimer,
    output logic [31:0] excptype,
    output logic [31:0] excp_pc,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall
);

    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [31:0] CODE_INT     = 32'h0000_0004;
    localparam logic [31:0] CODE_SYS     = 32'h0000_0100;
    localparam logic [31:0] CODE_ERET    = 32'h0000_0200;
    localparam logic [3:0]  HOLD_INIT    = 4'(HOLD_CYCLES);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state;
    logic [3:0]  hold_cnt;
    logic        timer_pend;
    logic        intimer_q;

    logic [31:0] eff_status;
    logic [31:0] eff_epc;
    logic        int_req;
    logic        can_take;
    logic        take_int;
    logic        take_sys;
    logic        take_eret;
    logic        event_taken;
    logic        unused_bits;

    // Forward an in-flight MTC0 to Status/EPC so it acts in the same cycle
    always_comb begin
        eff_status = (mem_cp0we && mem_cp0addr == ADDR_STATUS) ? mem_cp0wdata : status;
        eff_epc    = (mem_cp0we && mem_cp0addr == ADDR_EPC)    ? mem_cp0wdata : epc;
    end

    // Interrupt request and priority-resolved event selection
    always_comb begin
        int_req     = eff_status[0] && !eff_status[1] &&
                      (((cause[15:10] & eff_status[15:10]) != 6'd0) ||
                       (timer_pend && eff_status[15]));
        can_take    = !rst && (state == IDLE) && mem_valid;
        take_int    = can_take && int_req;
        take_sys    = can_take && !int_req && mem_syscall;
        take_eret   = can_take && !int_req && !mem_syscall && mem_eret;
        event_taken = take_int || take_sys || take_eret;
    end

    // Combinational CP0/front-end outputs for the current cycle
    always_comb begin
        excptype = '0;
        flush    = 1'b0;
        new_pc   = '0;
        excp_pc  = rst ? '0 : mem_pc;
        if (take_int) begin
            excptype = CODE_INT;
            flush    = 1'b1;
            new_pc   = HANDLER_ADDR;
        end else if (take_sys) begin
            excptype = CODE_SYS;
            flush    = 1'b1;
            new_pc   = HANDLER_ADDR;
        end else if (take_eret) begin
            excptype = CODE_ERET;
            flush    = 1'b1;
            new_pc   = eff_epc;
        end
    end

    // Timer pending latch: rising edge sets, taken interrupt or Compare write clears, set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_pend <= 1'b0;
            intimer_q  <= 1'b0;
        end else begin
            intimer_q <= intimer;
            if (intimer && !intimer_q)
                timer_pend <= 1'b1;
            else if (take_int || (mem_cp0we && mem_cp0addr == ADDR_COMPARE))
                timer_pend <= 1'b0;
        end
    end

    // IDLE/HOLD sequencer with registered stall covering the drain window
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (event_taken) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                        stall    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt <= 4'd1) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        stall    <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    stall    <= 1'b0;
                end
            endcase
        end
    end

    // Status/Cause fields this block does not interpret
    assign unused_bits = ^{cause[31:16], cause[9:0], eff_status[31:16], eff_status[9:2]};

endmodule

// File: tb/tb_excp_ctrl.sv
// tb_excp_ctrl: directed test-plan steps followed by randomized traffic,
// every cycle compared against a cycle-indexed behavioural model.
module tb_excp_ctrl;

    localparam int          H    = 2;
    localparam logic [31:0] HADR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_syscall;
    logic        mem_eret;
    logic        mem_cp0we;
    logic [4:0]  mem_cp0addr;
    logic [31:0] mem_cp0wdata;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        intimer;
    logic [31:0] excptype;
    logic [31:0] excp_pc;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall;

    excp_ctrl #(.HANDLER_ADDR(HADR), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_syscall(mem_syscall), .mem_eret(mem_eret), .mem_cp0we(mem_cp0we),
        .mem_cp0addr(mem_cp0addr), .mem_cp0wdata(mem_cp0wdata), .status(status),
        .cause(cause), .epc(epc), .intimer(intimer), .excptype(excptype),
        .excp_pc(excp_pc), .flush(flush), .new_pc(new_pc), .stall(stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cycle index, cycle of the last taken event, timer latch
    int cyc     = 0;
    int last_ev = -100;
    bit m_tp    = 1'b0;
    bit m_prev  = 1'b0;

    // Values the DUT showed in the most recent cycle
    logic [31:0] got_xt, got_npc, got_xpc;
    logic        got_fl, got_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: predict, compare mid-cycle, then advance the model at the edge
    task automatic do_cycle();
        logic [31:0] es, ee, xt, xpc, npc;
        bit st, ireq, tint, fl;
        @(negedge clk);
        st   = (cyc > last_ev) && (cyc <= last_ev + H);
        es   = (mem_cp0we && mem_cp0addr == 5'd12) ? mem_cp0wdata : status;
        ee   = (mem_cp0we && mem_cp0addr == 5'd14) ? mem_cp0wdata : epc;
        ireq = es[0] && !es[1] && (((cause[15:10] & es[15:10]) != 0) || (m_tp && es[15]));
        xt = 0; npc = 0; fl = 0; tint = 0;
        xpc = rst ? 32'h0 : mem_pc;
        if (!rst && !st && mem_valid) begin
            if (ireq) begin
                xt = 32'h4; npc = HADR; fl = 1; tint = 1;
            end else if (mem_syscall) begin
                xt = 32'h100; npc = HADR; fl = 1;
            end else if (mem_eret) begin
                xt = 32'h200; npc = ee; fl = 1;
            end
        end
        got_xt = excptype; got_npc = new_pc; got_xpc = excp_pc;
        got_fl = flush;    got_st  = stall;
        chk("excptype", excptype, xt);
        chk("excp_pc", excp_pc, xpc);
        chk("flush", {31'd0, flush}, {31'd0, fl});
        chk("new_pc", new_pc, npc);
        chk("stall", {31'd0, stall}, {31'd0, st});
        @(posedge clk);
        if (rst) begin
            m_tp = 0; m_prev = 0; last_ev = -100;
        end else begin
            if (fl) last_ev = cyc;
            if (tint || (mem_cp0we && mem_cp0addr == 5'd11)) m_tp = 0;
            if (intimer && !m_prev) m_tp = 1;
            m_prev = intimer;
        end
        cyc++;
        #1;
    endtask

    task automatic quiet(input int n);
        mem_valid = 0; mem_syscall = 0; mem_eret = 0; mem_cp0we = 0;
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        logic [4:0] addrs [5];
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        rst = 1; mem_valid = 0; mem_pc = 0; mem_syscall = 0; mem_eret = 0;
        mem_cp0we = 0; mem_cp0addr = 0; mem_cp0wdata = 0; status = 0;
        cause = 0; epc = 0; intimer = 0;
        @(posedge clk); #1;
        do_cycle();
        rst = 0;
        chk("reset_stall", {31'd0, got_st}, 32'd0);
        chk("reset_excptype", got_xt, 32'd0);

        // Syscall with drain window
        mem_valid = 1; mem_pc = 32'h100; mem_syscall = 1; status = 32'h1000_0001;
        do_cycle();
        chk("sys_code", got_xt, 32'h100);
        chk("sys_pc", got_xpc, 32'h100);
        chk("sys_newpc", got_npc, 32'h20);
        mem_syscall = 0; mem_pc = 32'h104;
        do_cycle(); chk("sys_stall1", {31'd0, got_st}, 32'd1);
        do_cycle(); chk("sys_stall2", {31'd0, got_st}, 32'd1);
        do_cycle(); chk("sys_stall_end", {31'd0, got_st}, 32'd0);

        // Eret with EPC forwarded from a concurrent MTC0
        quiet(3);
        mem_valid = 1; mem_eret = 1; epc = 32'h200; mem_pc = 32'h80;
        mem_cp0we = 1; mem_cp0addr = 5'd14; mem_cp0wdata = 32'h300;
        do_cycle();
        chk("eret_code", got_xt, 32'h200);
        chk("eret_newpc", got_npc, 32'h300);

        // Timer interrupt deferred across invalid cycles
        quiet(3);
        status = 32'h0000_8001; intimer = 1;
        quiet(3);
        mem_valid = 1; mem_pc = 32'h40;
        do_cycle();
        chk("tmr_code", got_xt, 32'h4);
        chk("tmr_pc", got_xpc, 32'h40);
        quiet(3);
        mem_valid = 1;
        do_cycle();
        chk("tmr_cleared", got_xt, 32'h0);

        // EXL masks; forwarded Status write unmasks in the same cycle
        quiet(3);
        cause = 32'h400; status = 32'h403; mem_valid = 1;
        do_cycle();
        chk("exl_mask", got_xt, 32'h0);
        mem_cp0we = 1; mem_cp0addr = 5'd12; mem_cp0wdata = 32'h401;
        do_cycle();
        chk("fwd_int", got_xt, 32'h4);

        // Interrupt beats syscall
        quiet(3);
        status = 32'h401; mem_valid = 1; mem_syscall = 1;
        do_cycle();
        chk("prio_code", got_xt, 32'h4);
        chk("prio_newpc", got_npc, 32'h20);

        // Reset in the first HOLD cycle, then the syscall is taken again
        quiet(3);
        cause = 0; mem_valid = 1; mem_syscall = 1;
        do_cycle();
        chk("rst_sys", got_xt, 32'h100);
        rst = 1;
        do_cycle();
        chk("rst_quiet", got_xt, 32'h0);
        rst = 0;
        do_cycle();
        chk("rst_stall_low", {31'd0, got_st}, 32'd0);
        chk("rst_retake", got_xt, 32'h100);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] s;
            rst         = ($urandom_range(0, 49) == 0);
            mem_valid   = ($urandom_range(0, 9) < 7);
            mem_pc      = $urandom & 32'hFFFF_FFFC;
            mem_syscall = ($urandom_range(0, 4) == 0);
            mem_eret    = ($urandom_range(0, 7) == 0);
            mem_cp0we   = ($urandom_range(0, 4) == 0);
            mem_cp0addr = addrs[$urandom_range(0, 4)];
            s = $urandom; s[0] = ($urandom_range(0, 4) != 0); s[1] = ($urandom_range(0, 4) == 0);
            mem_cp0wdata = s;
            s = $urandom; s[0] = ($urandom_range(0, 4) != 0); s[1] = ($urandom_range(0, 4) == 0);
            status = s;
            s = $urandom; s[15:10] = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
            cause = s;
            epc   = $urandom;
            if ($urandom_range(0, 7) == 0) intimer = ~intimer;
            do_cycle();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt sequencer between the MEM pipeline stage and the CP0 register block. Each cycle it evaluates the instruction in MEM against pending hardware/timer interrupts and the Status/Cause state. It selects one event (interrupt, syscall, eret) and drives the CP0 `excptype`/`pc` inputs. It also issues a pipeline flush with a redirect PC, then holds the front end for a fixed drain window before accepting the next event.

## Interface
Parameters:
- HANDLER_ADDR, 32'h0000_0020, redirect target for interrupt and syscall
- HOLD_CYCLES, 2, stall cycles after a taken event (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc  in  32  PC of the MEM instruction
- mem_syscall  in  1  MEM instruction is SYSCALL
- mem_eret  in  1  MEM instruction is ERET
- mem_cp0we  in  1  MEM instruction writes CP0 this cycle (MTC0)
- mem_cp0addr  in  5  CP0 write address
- mem_cp0wdata  in  32  CP0 write data
- status  in  32  CP0 Status
- cause  in  32  CP0 Cause (bits 15:10 = live hardware interrupt lines)
- epc  in  32  CP0 EPC
- intimer  in  1  CP0 timer interrupt level
- excptype  out  32  event code to CP0: 0x4 interrupt, 0x100 syscall, 0x200 eret, 0 none
- excp_pc  out  32  PC handed to CP0 for EPC capture
- flush  out  1  kill IF..MEM, one cycle
- new_pc  out  32  redirect target, valid when flush=1
- stall  out  1  freeze fetch during drain window

## Operation
- CP0 addresses: Count 9, Compare 11, Status 12, Cause 13, EPC 14.
- Effective Status/EPC are forwarded from the MEM write. If mem_cp0we and addr==12, eff_status=mem_cp0wdata, else status. If mem_cp0we and addr==14, eff_epc=mem_cp0wdata, else epc.
- Timer pending latch timer_pend:
  - A rising edge of intimer, registered against the previous cycle's value, sets it.
  - A taken interrupt clears it. A CP0 write to Compare (addr 11) in MEM also clears it.
  - If a set and a clear occur in the same cycle, the set wins.
- int_req = eff_status[0] (IE) & ~eff_status[1] (EXL) & (((cause[15:10] & eff_status[15:10]) != 0) | (timer_pend & eff_status[15])).
- FSM states IDLE, HOLD.
  - Events are evaluated only in IDLE with mem_valid=1.
  - Priority: interrupt > syscall > eret. Exactly one event is taken per cycle.
  - Interrupt: excptype=0x4, excp_pc=mem_pc, new_pc=HANDLER_ADDR.
  - Syscall: excptype=0x100, excp_pc=mem_pc (CP0 adds 4), new_pc=HANDLER_ADDR.
  - Eret: excptype=0x200, excp_pc=mem_pc, new_pc=eff_epc.
  - A taken event asserts flush=1 for that cycle, and the next state is HOLD with hold counter = HOLD_CYCLES.
  - HOLD: stall=1, excptype=0, flush=0. The counter decrements each cycle, and the FSM returns to IDLE on the cycle the counter reaches 0. Interrupts arriving during HOLD stay latched (hardware lines are level; timer via timer_pend) and are evaluated in the first IDLE cycle.
- No event: excptype=0, flush=0, new_pc=0, excp_pc=mem_pc.
- A syscall/eret with mem_valid=0 is ignored. An interrupt with mem_valid=0 is deferred, never dropped.

## Timing
- Event detection is combinational in the IDLE cycle T. excptype, excp_pc, flush and new_pc are valid during T.
- CP0 commits EPC/EXL at the posedge ending T. The front end loads new_pc at the same edge.
- stall is high for cycles T+1 .. T+HOLD_CYCLES, and the next event is possible at T+HOLD_CYCLES+1.
- stall and state are registered outputs. excptype, flush, new_pc and excp_pc are combinational from registered state plus inputs.
- Reset values: state IDLE, counter 0, timer_pend 0, prev intimer 0, stall 0, flush 0, excptype 0, new_pc 0, excp_pc 0.
- Reset asserted during HOLD returns to IDLE at the next edge with stall=0. No event is emitted while rst=1.

## Test plan
- Syscall with mem_pc=0x100, Status=0x10000001 -> excptype=0x100, excp_pc=0x100, flush=1, new_pc=0x20 in one cycle; stall=1 for the next 2 cycles, then 0.
- Eret with epc=0x200 while MEM also does MTC0 EPC=0x300 -> new_pc=0x300, excptype=0x200.
- intimer rises, Status=0x00008001 (IE=1, IM7=1), mem_valid=0 for 3 cycles, then 1 with mem_pc=0x40 -> interrupt taken on the first valid cycle: excptype=0x4, excp_pc=0x40; timer_pend then 0.
- cause[10]=1, Status=0x00000403 (EXL=1) -> no event. MTC0 Status=0x00000401 in MEM -> interrupt taken that same cycle via forwarding.
- Interrupt and syscall in the same cycle -> excptype=0x4 only. The syscall instruction is flushed and new_pc=0x20.
- rst asserted in the first HOLD cycle -> next cycle stall=0, state IDLE, excptype=0, and a pending syscall is taken normally afterwards.
